// File: rtl/usb_pin_conditioner_if.sv
// Signal bundle between the SoC-side USB PIO exports, the MAX3421E pins and the
// pin conditioner. The master drives raw pins and requests; the slave is the conditioner.
interface usb_pin_conditioner_if;
    logic       usb_rst_req_n;
    logic       max_int;
    logic       max_gpx;
    logic       spi_ss_n;
    logic       status_clr;
    logic       max_res_n;
    logic       usb_irq_export;
    logic       usb_gpx_export;
    logic       ready;
    logic       ss_timeout;
    logic [7:0] irq_count;

    modport master (
        output usb_rst_req_n, max_int, max_gpx, spi_ss_n, status_clr,
        input  max_res_n, usb_irq_export, usb_gpx_export, ready, ss_timeout, irq_count
    );

    modport slave (
        input  usb_rst_req_n, max_int, max_gpx, spi_ss_n, status_clr,
        output max_res_n, usb_irq_export, usb_gpx_export, ready, ss_timeout, irq_count
    );
endinterface

// File: rtl/usb_pin_conditioner.sv
// MAX3421E pin conditioner: input synchronizers, INT/GPX deglitch, RES pulse and
// hold-off sequencing, SS_n stuck-transaction watchdog and interrupt counter.
module usb_pin_conditioner #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEGLITCH_CYCLES   = 4,
    parameter int RST_MIN_CYCLES    = 500,
    parameter int HOLDOFF_CYCLES    = 50000,
    parameter int SS_TIMEOUT_CYCLES = 65535,
    parameter bit INT_ACTIVE_LOW    = 1'b1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    usb_pin_conditioner_if.slave  io_usb
);

    localparam int DG_W    = $clog2(DEGLITCH_CYCLES + 1);
    localparam int FSM_MAX = (RST_MIN_CYCLES > HOLDOFF_CYCLES) ? RST_MIN_CYCLES : HOLDOFF_CYCLES;
    localparam int FSM_W   = $clog2(FSM_MAX + 1);
    localparam int SS_W    = $clog2(SS_TIMEOUT_CYCLES + 1);

    localparam logic [DG_W-1:0]  DG_LAST   = DG_W'(DEGLITCH_CYCLES - 1);
    localparam logic [FSM_W-1:0] RST_LOAD  = FSM_W'(RST_MIN_CYCLES - 1);
    localparam logic [FSM_W-1:0] HOLD_LOAD = FSM_W'(HOLDOFF_CYCLES - 1);
    localparam logic [SS_W-1:0]  SS_MAX    = SS_W'(SS_TIMEOUT_CYCLES);
    localparam logic [SS_W-1:0]  SS_LAST   = SS_W'(SS_TIMEOUT_CYCLES - 1);
    localparam logic             INT_IDLE  = INT_ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_RST_ASSERT = 2'd0,
        ST_HOLDOFF    = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    // One deglitch step: returns {next filtered level, next stability count}.
    function automatic logic [DG_W:0] dg_step(input logic raw, input logic filt,
                                              input logic [DG_W-1:0] cnt);
        if (raw == filt)
            return {filt, {DG_W{1'b0}}};
        else if (cnt == DG_LAST)
            return {raw, {DG_W{1'b0}}};
        else
            return {filt, cnt + 1'b1};
    endfunction

    logic [SYNC_STAGES-1:0] r_int_sync;
    logic [SYNC_STAGES-1:0] r_gpx_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_req_sync;

    logic w_int_raw, w_gpx_raw, w_ss_low, w_req_n;

    logic            r_int_filt, r_gpx_filt;
    logic [DG_W-1:0] r_int_dg_cnt, r_gpx_dg_cnt;
    logic            w_int_filt_nxt, w_gpx_filt_nxt;
    logic [DG_W-1:0] w_int_dg_nxt, w_gpx_dg_nxt;

    state_t           r_state;
    logic [FSM_W-1:0] r_cnt;
    logic             r_res_n, r_ready, r_irq_out, r_gpx_out;

    logic            r_irq_prev;
    logic [7:0]      r_irq_count;
    logic            w_irq_rise;
    logic [SS_W-1:0] r_ss_cnt;
    logic            r_ss_timeout;

    // Synchronizer stage: every downstream decision uses only these flops.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_int_sync <= {SYNC_STAGES{INT_IDLE}};
            r_gpx_sync <= '0;
            r_ss_sync  <= '1;
            r_req_sync <= '1;
        end else begin
            r_int_sync <= {r_int_sync[SYNC_STAGES-2:0], io_usb.max_int};
            r_gpx_sync <= {r_gpx_sync[SYNC_STAGES-2:0], io_usb.max_gpx};
            r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0],  io_usb.spi_ss_n};
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], io_usb.usb_rst_req_n};
        end
    end

    assign w_int_raw = r_int_sync[SYNC_STAGES-1] ^ INT_ACTIVE_LOW;
    assign w_gpx_raw = r_gpx_sync[SYNC_STAGES-1];
    assign w_ss_low  = ~r_ss_sync[SYNC_STAGES-1];
    assign w_req_n   = r_req_sync[SYNC_STAGES-1];

    assign {w_int_filt_nxt, w_int_dg_nxt} = dg_step(w_int_raw, r_int_filt, r_int_dg_cnt);
    assign {w_gpx_filt_nxt, w_gpx_dg_nxt} = dg_step(w_gpx_raw, r_gpx_filt, r_gpx_dg_cnt);

    // Deglitch stage
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_int_filt   <= 1'b0;
            r_gpx_filt   <= 1'b0;
            r_int_dg_cnt <= '0;
            r_gpx_dg_cnt <= '0;
        end else begin
            r_int_filt   <= w_int_filt_nxt;
            r_gpx_filt   <= w_gpx_filt_nxt;
            r_int_dg_cnt <= w_int_dg_nxt;
            r_gpx_dg_cnt <= w_gpx_dg_nxt;
        end
    end

    // Reset sequencer. Outputs load the filter's next level so the exported
    // pins track the filtered level on the same edge it changes.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state   <= ST_RST_ASSERT;
            r_cnt     <= RST_LOAD;
            r_res_n   <= 1'b0;
            r_ready   <= 1'b0;
            r_irq_out <= 1'b0;
            r_gpx_out <= 1'b0;
        end else begin
            case (r_state)
                ST_RST_ASSERT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_req_n) begin
                        r_state <= ST_HOLDOFF;
                        r_cnt   <= HOLD_LOAD;
                        r_res_n <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (!w_req_n) begin
                        r_state <= ST_RST_ASSERT;
                        r_cnt   <= RST_LOAD;
                        r_res_n <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_RUN;
                        r_ready   <= 1'b1;
                        r_irq_out <= w_int_filt_nxt;
                        r_gpx_out <= w_gpx_filt_nxt;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_req_n) begin
                        r_state   <= ST_RST_ASSERT;
                        r_cnt     <= RST_LOAD;
                        r_res_n   <= 1'b0;
                        r_ready   <= 1'b0;
                        r_irq_out <= 1'b0;
                        r_gpx_out <= 1'b0;
                    end else begin
                        r_irq_out <= w_int_filt_nxt;
                        r_gpx_out <= w_gpx_filt_nxt;
                    end
                end
                default: begin
                    r_state   <= ST_RST_ASSERT;
                    r_cnt     <= RST_LOAD;
                    r_res_n   <= 1'b0;
                    r_ready   <= 1'b0;
                    r_irq_out <= 1'b0;
                    r_gpx_out <= 1'b0;
                end
            endcase
        end
    end

    assign w_irq_rise = r_irq_out & ~r_irq_prev;

    // Status stage: clear beats a coincident increment; the watchdog count is
    // left running by status_clr, so a still-low SS_n re-flags next cycle.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_irq_prev   <= 1'b0;
            r_irq_count  <= '0;
            r_ss_cnt     <= '0;
            r_ss_timeout <= 1'b0;
        end else begin
            r_irq_prev <= r_irq_out;
            if (io_usb.status_clr)
                r_irq_count <= '0;
            else if (w_irq_rise && r_irq_count != 8'hFF)
                r_irq_count <= r_irq_count + 8'd1;

            if (!w_ss_low)
                r_ss_cnt <= '0;
            else if (r_ss_cnt != SS_MAX)
                r_ss_cnt <= r_ss_cnt + 1'b1;

            if (io_usb.status_clr)
                r_ss_timeout <= 1'b0;
            else if (w_ss_low && r_ss_cnt >= SS_LAST)
                r_ss_timeout <= 1'b1;
        end
    end

    assign io_usb.max_res_n      = r_res_n;
    assign io_usb.ready          = r_ready;
    assign io_usb.usb_irq_export = r_irq_out;
    assign io_usb.usb_gpx_export = r_gpx_out;
    assign io_usb.irq_count      = r_irq_count;
    assign io_usb.ss_timeout     = r_ss_timeout;

endmodule

// File: tb/tb_usb_pin_conditioner.sv
// Self-checking bench for usb_pin_conditioner with short reset/hold-off/timeout parameters.
module tb_usb_pin_conditioner;
    localparam int SYNC = 2;
    localparam int DG   = 4;
    localparam int RSTC = 8;
    localparam int HOLD = 16;
    localparam int SST  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_pin_conditioner_if u_if();

    usb_pin_conditioner #(
        .SYNC_STAGES(SYNC), .DEGLITCH_CYCLES(DG), .RST_MIN_CYCLES(RSTC),
        .HOLDOFF_CYCLES(HOLD), .SS_TIMEOUT_CYCLES(SST), .INT_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .io_usb(u_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit prop;
        bit gpx;
    } vec_t;

    typedef struct {
        string nm;
        int    exp_lat;
        int    exp_cnt;
    } sb_t;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb_q[$];
    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_int(input bit act);
        u_if.max_int = ~act;
    endtask

    task automatic clr_pulse();
        u_if.status_clr = 1'b1;
        tick();
        u_if.status_clr = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_res_n"}, int'(u_if.max_res_n), 0);
        chk({tag, "_irq"},   int'(u_if.usb_irq_export), 0);
        chk({tag, "_gpx"},   int'(u_if.usb_gpx_export), 0);
        chk({tag, "_ready"}, int'(u_if.ready), 0);
        chk({tag, "_sstmo"}, int'(u_if.ss_timeout), 0);
        chk({tag, "_cnt"},   int'(u_if.irq_count), 0);
    endtask

    // Releases reset with INT held active, checks pulse width, hold-off and masking.
    task automatic reset_seq(input string tag);
        int n, m;
        bit irq_seen;
        set_int(1'b1);
        rst = 1'b0;
        n = 0; irq_seen = 1'b0;
        do begin
            tick(); n++;
            irq_seen |= u_if.usb_irq_export;
        end while (!u_if.max_res_n && n < 100);
        chk({tag, "_res_width"}, n, RSTC);
        m = 0;
        do begin
            tick(); m++;
            if (!u_if.ready) irq_seen |= u_if.usb_irq_export;
        end while (!u_if.ready && m < 100);
        chk({tag, "_holdoff"}, m, HOLD);
        chk({tag, "_irq_masked"}, int'(irq_seen), 0);
        chk({tag, "_irq_at_ready"}, int'(u_if.usb_irq_export), 1);
        set_int(1'b0);
        repeat (12) tick();
        chk({tag, "_cnt_after_ready"}, int'(u_if.irq_count), 1);
        clr_pulse();
        chk({tag, "_cnt_clr"}, int'(u_if.irq_count), 0);
    endtask

    // Drops req_n, raises it again at tick 'hold'; returns fall latency and low width.
    task automatic req_pulse(input int hold, output int fall, output int width);
        int t, rise;
        fall = 0; rise = 0; t = 0;
        u_if.usb_rst_req_n = 1'b0;
        while (rise == 0 && t < 200) begin
            tick(); t++;
            if (!u_if.max_res_n && fall == 0) fall = t;
            if (u_if.max_res_n && fall != 0) rise = t;
            if (t == hold) u_if.usb_rst_req_n = 1'b1;
        end
        u_if.usb_rst_req_n = 1'b1;
        width = (rise == 0) ? -1 : rise - fall;
    endtask

    task automatic wait_ready(output int m);
        m = 0;
        do begin tick(); m++; end while (!u_if.ready && m < 100);
    endtask

    task automatic int_pulse();
        set_int(1'b1);
        repeat (5) tick();
        set_int(1'b0);
        repeat (8) tick();
    endtask

    initial begin
        int exp_cnt, lat, fall, width, m, t, set_t;
        sb_t e;

        vecs[0] = '{len: 1, prop: 1'b0, gpx: 1'b0};
        vecs[1] = '{len: 2, prop: 1'b0, gpx: 1'b0};
        vecs[2] = '{len: 3, prop: 1'b0, gpx: 1'b0};
        vecs[3] = '{len: 4, prop: 1'b1, gpx: 1'b0};
        vecs[4] = '{len: 6, prop: 1'b1, gpx: 1'b0};
        vecs[5] = '{len: 3, prop: 1'b0, gpx: 1'b1};
        vecs[6] = '{len: 4, prop: 1'b1, gpx: 1'b1};

        u_if.usb_rst_req_n = 1'b1;
        u_if.max_int       = 1'b1;
        u_if.max_gpx       = 1'b0;
        u_if.spi_ss_n      = 1'b1;
        u_if.status_clr    = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");

        reset_seq("boot");

        // Glitch table in RUN
        exp_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].prop && !vecs[i].gpx) exp_cnt++;
            sb_q.push_back('{nm: $sformatf("vec%0d", i),
                             exp_lat: vecs[i].prop ? SYNC + DG : 0,
                             exp_cnt: exp_cnt});
            if (vecs[i].gpx) u_if.max_gpx = 1'b1; else set_int(1'b1);
            lat = 0;
            for (int k = 1; k <= vecs[i].len + 14; k++) begin
                tick();
                if (lat == 0 && (vecs[i].gpx ? u_if.usb_gpx_export : u_if.usb_irq_export)) lat = k;
                if (k == vecs[i].len) begin
                    if (vecs[i].gpx) u_if.max_gpx = 1'b0; else set_int(1'b0);
                end
            end
            e = sb_q.pop_front();
            chk({e.nm, "_lat"}, lat, e.exp_lat);
            chk({e.nm, "_cnt"}, int'(u_if.irq_count), e.exp_cnt);
        end

        // Reset re-request from RUN, then again from HOLDOFF
        req_pulse(30, fall, width);
        chk("rereq_fall_lat", fall, SYNC + 1);
        chk("rereq_width", width, 30);
        chk("rereq_ready_low", int'(u_if.ready), 0);
        repeat (10) tick();
        req_pulse(3, fall, width);
        chk("hold_rereq_fall_lat", fall, SYNC + 1);
        chk("hold_rereq_width", width, RSTC);
        wait_ready(m);
        chk("hold_rereq_holdoff", m, HOLD);

        // Saturation then clear coincident with 301st rising edge
        clr_pulse();
        exp_cnt = 0;
        for (int p = 1; p <= 300; p++) begin
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            sb_q.push_back('{nm: $sformatf("sat%0d", p), exp_lat: 0, exp_cnt: exp_cnt});
            int_pulse();
            e = sb_q.pop_front();
            chk(e.nm, int'(u_if.irq_count), e.exp_cnt);
        end
        set_int(1'b1);
        t = 0;
        do begin tick(); t++; end while (!u_if.usb_irq_export && t < 20);
        chk("p301_rise_lat", t, SYNC + DG);
        clr_pulse();
        chk("p301_clr_wins", int'(u_if.irq_count), 0);
        set_int(1'b0);
        repeat (10) tick();
        chk("p301_after_fall", int'(u_if.irq_count), 0);

        // SS watchdog
        u_if.spi_ss_n = 1'b0;
        repeat (19) tick();
        u_if.spi_ss_n = 1'b1;
        repeat (5) tick();
        chk("ss_19_no_timeout", int'(u_if.ss_timeout), 0);
        u_if.spi_ss_n = 1'b0;
        set_t = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (u_if.ss_timeout && set_t == 0) set_t = k;
            if (k == 25) u_if.spi_ss_n = 1'b1;
        end
        chk("ss_set_time", set_t, SYNC + SST);
        chk("ss_sticky", int'(u_if.ss_timeout), 1);
        clr_pulse();
        chk("ss_clr", int'(u_if.ss_timeout), 0);
        u_if.spi_ss_n = 1'b0;
        repeat (25) tick();
        clr_pulse();
        chk("ss_clr_while_low", int'(u_if.ss_timeout), 0);
        tick();
        chk("ss_reflag_while_low", int'(u_if.ss_timeout), 1);
        u_if.spi_ss_n = 1'b1;

        // Async reset mid-HOLDOFF with nonzero status
        int_pulse();
        chk("pre_async_cnt", int'(u_if.irq_count), 1);
        req_pulse(3, fall, width);
        repeat (5) tick();
        chk("pre_async_in_holdoff", int'(u_if.max_res_n) + int'(u_if.ready) * 2, 1);
        #3 rst = 1'b1;
        #1;
        chk_reset_vals("async");
        tick();
        reset_seq("reboot");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
